// File: rtl/iir_coeff_ctrl.sv
// Run-time coefficient controller for iir_filter.
// Coefficient writes go to shadow registers. A commit stalls the sample stream
// and waits for the filter to drain. The shadow set then moves into the active
// buses in a single cycle, so no output sample ever sees a mixed set.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   src_valid/src_data     upstream sample; src_ready accepts it (combinational)
//   cfg_we/addr/data       shadow write (addr 0-1 fb, 2-5 ff, 6-7 dropped)
//   cfg_commit             request shadow->active swap
//   cfg_busy, swap_done    swap in progress / one-cycle "new set active" pulse
//   flt_vIn/flt_dIn        sample to filter (combinational pass-through)
//   coeffs_fb/coeffs_ff    active coefficient buses, coefficient i at [WL*i +: WL]
//   flt_vOut               filter output valid, used for in-flight tracking
module iir_coeff_ctrl #(
    parameter int unsigned NB      = 12,
    parameter int unsigned WL      = 24,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            src_valid,
    input  logic [NB-1:0]   src_data,
    output logic            src_ready,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [WL-1:0]   cfg_data,
    input  logic            cfg_commit,
    output logic            cfg_busy,
    output logic            swap_done,
    output logic            flt_vIn,
    output logic [NB-1:0]   flt_dIn,
    output logic [2*WL-1:0] coeffs_fb,
    output logic [4*WL-1:0] coeffs_ff,
    input  logic            flt_vOut
);

    localparam int unsigned CW    = $clog2(MAX_OUT + 1);
    localparam int unsigned NCOEF = 6;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            cnt_dec;
    logic            wr_en;
    logic [WL-1:0]   shadow [NCOEF];
    logic [2*WL-1:0] fb_q;
    logic [4*WL-1:0] ff_q;
    logic            swap_done_q;
    logic            busy_q;

    // Sample path: combinational pass-through, gated while swapping or full.
    assign src_ready = (state == RUN) && (cnt < CW'(MAX_OUT));
    assign flt_vIn   = src_valid && src_ready;
    assign flt_dIn   = src_data;

    // A stray vOut with nothing in flight is ignored.
    assign cnt_dec = flt_vOut && (cnt != '0);
    assign wr_en   = (state == RUN) && cfg_we && (cfg_addr < 3'd6);

    assign coeffs_fb = fb_q;
    assign coeffs_ff = ff_q;
    assign swap_done = swap_done_q;
    assign cfg_busy  = busy_q;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_commit) state_nxt = HOLD;
            HOLD:    if (cnt == '0) state_nxt = SWAP;
            SWAP:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // State register plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            swap_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            swap_done_q <= (state == SWAP);
            busy_q      <= (state_nxt != RUN);
        end
    end

    // In-flight sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({flt_vIn, cnt_dec})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Shadow registers; a write in the commit cycle still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NCOEF; i++) begin
                if (wr_en && (cfg_addr == 3'(i))) shadow[i] <= cfg_data;
            end
        end
    end

    // Active set, loaded only at the end of SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_q <= '0;
            ff_q <= '0;
        end else if (state == SWAP) begin
            fb_q <= {shadow[1], shadow[0]};
            ff_q <= {shadow[5], shadow[4], shadow[3], shadow[2]};
        end
    end

endmodule
